expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//  Downstream companion of the character-stream syntax checker: samples the same 8-bit ASCII
//  stream (one char per clk) and computes the integer value of an expression of the form
//  digit ((+|*) digit)*, with '*' binding tighter than '+'. Emits a running result that is
//  valid whenever the prefix seen so far is a complete, well-formed expression.
//  Sticky error on a syntax violation, until clr.
// PARAMETERS
//  W  16  result / accumulator width in bits; all arithmetic is modulo 2^W
// PORTS
//  clk     in   1  clock, rising edge
//  clr     in   1  reset, synchronous, active-high
//  in      in   8  ASCII character, sampled every rising clk edge
//  out     out  1  1 = chars since clr form a complete valid expression
//  result  out  W  value of the expression; meaningful only while out=1
//  err     out  1  sticky: a syntax violation was seen since the last clr
// BEHAVIOUR
//  - Reset: clr high at a rising edge -> state=START, sum=0, term=0, result=0, out=0, err=0.
//    clr overrides any char on that edge; mid-expression clr discards all partial values.
//  - Char classes: DIGIT "0".."9" (d = in-8'h30), ADD "+", MUL "*", OTHER = everything else.
//    OTHER is ignored in every state: no register changes.
//  - States:
//      START  nothing accepted yet
//      NUM    last accepted char was a digit (the only state with out=1)
//      ADD    last accepted char was '+'
//      MUL    last accepted char was '*'
//      ERR    absorbing until clr
//  - Transitions and datapath, applied at the edge that samples in:
//      START: DIGIT -> NUM, sum<=0, term<=d;   ADD/MUL -> ERR
//      NUM  : DIGIT -> ERR (multi-digit numbers are illegal); ADD -> ADD; MUL -> MUL
//      ADD  : DIGIT -> NUM, sum<=sum+term, term<=d;   ADD/MUL -> ERR
//      MUL  : DIGIT -> NUM, term<=term*d (sum unchanged);   ADD/MUL -> ERR
//      ERR  : stays ERR for every char
//  - Outputs are registered, 1-cycle latency: after the edge that samples char c, out/result/err
//    reflect the string up to and including c.
//      out    <= (next state == NUM)
//      err    <= (next state == ERR)
//      result <= next_sum + next_term, updated only on a transition into NUM;
//                holds its last value otherwise (including in ADD, MUL and ERR)
//  - Width: term*d is computed as W x 4 bits and truncated to W; the sum is truncated to W.
//    No overflow flag; wrap-around is the required behaviour.
//  - A trailing operator leaves out=0 while result holds the value of the last complete prefix.
// STRUCTURE
//  - Package expr_pkg: ASCII constants (CH_0, CH_9, CH_ADD, CH_MUL) and a state enum
//    {START, NUM, ADD, MUL, ERR} encoded in 3 bits.
//  - Sub-module char_class (combinational): in -> is_digit, is_add, is_mul, digit[3:0].
//    Shared with the syntax checker so both stages classify chars identically.
//  - Top: state register, sum/term registers, next-value logic, output registers.
// TESTING
//  1. clr, then "1","+","2","*","3" -> out=1, result=7 after the last edge; out=0 after "+" and "*".
//  2. "2*3*4+5" -> out=1 and result=29 after "5"; result=24 holds while in ADD after "+".
//  3. "3"," ","+","x","4" (space/x ignored) -> result=7, out=1, err=0.
//  4. Errors: "12" -> err=1 and out=0 after "2"; "+1" -> err=1 after "+";
//     "1++2" -> err=1, and it stays 1 on any later input.
//  5. W=8, "9*9*9*9" -> result=161 (6561 mod 256), out=1.
//  6. clr asserted with in="5" during "1+2": next cycle state=START, out=0, result=0, err=0;
//     then "4" -> result=4, out=1.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared ASCII constants and evaluator state encoding for the expression pipeline.
package expr_pkg;

  localparam int unsigned CHAR_W = 8;

  localparam logic [CHAR_W-1:0] CH_0   = 8'h30;
  localparam logic [CHAR_W-1:0] CH_9   = 8'h39;
  localparam logic [CHAR_W-1:0] CH_ADD = 8'h2B;
  localparam logic [CHAR_W-1:0] CH_MUL = 8'h2A;

  typedef enum logic [2:0] {
    START = 3'd0,
    NUM   = 3'd1,
    ADD   = 3'd2,
    MUL   = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier shared by the syntax checker and the evaluator.
module char_class
  import expr_pkg::*;
(
  input  logic [CHAR_W-1:0] in,
  output logic              is_digit,
  output logic              is_add,
  output logic              is_mul,
  output logic [3:0]        digit
);

  assign is_digit = (in >= CH_0) && (in <= CH_9);
  assign is_add   = (in == CH_ADD);
  assign is_mul   = (in == CH_MUL);
  // '0' is 8'h30, so the low nibble of a digit char is its value.
  assign digit    = in[3:0];

endmodule

// File: rtl/expr_eval.sv
// Evaluates digit((+|*)digit)* on a char stream, '*' binding tighter than '+', modulo 2^W.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [CHAR_W-1:0] in,
  output logic              out,
  output logic [W-1:0]      result,
  output logic              err
);

  logic         is_digit;
  logic         is_add;
  logic         is_mul;
  logic [3:0]   digit;

  state_t       state;
  state_t       next_state;
  logic [W-1:0] sum;
  logic [W-1:0] term;
  logic [W-1:0] next_sum;
  logic [W-1:0] next_term;
  logic         enter_num;

  char_class u_char_class (
    .in       (in),
    .is_digit (is_digit),
    .is_add   (is_add),
    .is_mul   (is_mul),
    .digit    (digit)
  );

  // Next state and datapath; OTHER chars fall through with everything held.
  always_comb begin
    next_state = state;
    next_sum   = sum;
    next_term  = term;
    enter_num  = 1'b0;
    case (state)
      START: begin
        if (is_digit) begin
          next_state = NUM;
          next_sum   = '0;
          next_term  = W'(digit);
          enter_num  = 1'b1;
        end else if (is_add || is_mul) begin
          next_state = ERR;
        end
      end
      NUM: begin
        if (is_digit)    next_state = ERR;
        else if (is_add) next_state = ADD;
        else if (is_mul) next_state = MUL;
      end
      ADD: begin
        if (is_digit) begin
          next_state = NUM;
          next_sum   = W'(sum + term);
          next_term  = W'(digit);
          enter_num  = 1'b1;
        end else if (is_add || is_mul) begin
          next_state = ERR;
        end
      end
      MUL: begin
        if (is_digit) begin
          next_state = NUM;
          next_term  = W'(term * W'(digit));
          enter_num  = 1'b1;
        end else if (is_add || is_mul) begin
          next_state = ERR;
        end
      end
      ERR:     next_state = ERR;
      default: next_state = ERR;
    endcase
  end

  // Registers; result only moves when a complete expression is formed.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= START;
      sum    <= '0;
      term   <= '0;
      result <= '0;
      out    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= next_state;
      sum   <= next_sum;
      term  <= next_term;
      out   <= (next_state == NUM);
      err   <= (next_state == ERR);
      if (enter_num) result <= W'(next_sum + next_term);
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: directed cases plus random streams against a string-level reference model.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  in  = 8'h20;

  logic        out16, err16;
  logic [15:0] res16;
  logic        out8, err8;
  logic [7:0]  res8;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model: accepted chars since clr, sticky error, last complete value.
  logic [7:0]  q[$];
  bit          m_err;
  int unsigned m_res;

  expr_eval #(.W(16)) dut16 (
    .clk(clk), .clr(clr), .in(in), .out(out16), .result(res16), .err(err16)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in(in), .out(out8), .result(res8), .err(err8)
  );

  always #5 clk = ~clk;

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_op(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2A);
  endfunction

  // Sum of products over the accepted string, wrapping at 32 bits (callers mask to W).
  function automatic int unsigned eval_q();
    int unsigned s = 0;
    int unsigned p = 1;
    foreach (q[i]) begin
      if (is_dig(q[i]))       p = p * int'(q[i] - 8'h30);
      else if (q[i] == 8'h2B) begin s = s + p; p = 1; end
    end
    return s + p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c_clr, input logic [7:0] c);
    bit m_out;
    bit want_digit;
    clr = c_clr;
    in  = c;
    if (c_clr) begin
      q.delete();
      m_err = 1'b0;
      m_res = 0;
    end else if (!m_err && (is_dig(c) || is_op(c))) begin
      want_digit = (q.size() == 0) || is_op(q[$]);
      if (is_dig(c) != want_digit) m_err = 1'b1;
      else begin
        q.push_back(c);
        if (is_dig(c)) m_res = eval_q();
      end
    end
    m_out = !m_err && (q.size() > 0) && is_dig(q[$]);
    @(posedge clk);
    #1;
    chk("out16", 32'(out16), 32'(m_out));
    chk("err16", 32'(err16), 32'(m_err));
    chk("res16", 32'(res16), 32'(m_res[15:0]));
    chk("out8",  32'(out8),  32'(m_out));
    chk("err8",  32'(err8),  32'(m_err));
    chk("res8",  32'(res8),  32'(m_res[7:0]));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, s[i]);
  endtask

  initial begin
    string other_chars;
    int unsigned r;
    bit want_digit;
    logic [7:0] c;
    other_chars = " x=-a(/.";
    m_err = 1'b0;
    m_res = 0;

    // Reset state, clr overriding a digit on the same edge.
    step(1'b1, 8'h35);
    chk("rst_out", 32'(out16), 32'd0);
    chk("rst_res", 32'(res16), 32'd0);

    send_str("1+");
    chk("t1_plus_out", 32'(out16), 32'd0);
    send_str("2*");
    chk("t1_mul_out", 32'(out16), 32'd0);
    send_str("3");
    chk("t1_result", 32'(res16), 32'd7);
    chk("t1_out", 32'(out16), 32'd1);

    step(1'b1, 8'h20);
    send_str("2*3*4+");
    chk("t2_hold", 32'(res16), 32'd24);
    send_str("5");
    chk("t2_result", 32'(res16), 32'd29);

    step(1'b1, 8'h20);
    send_str("3 +x4");
    chk("t3_result", 32'(res16), 32'd7);
    chk("t3_err", 32'(err16), 32'd0);

    step(1'b1, 8'h20);
    send_str("12");
    chk("t4_multi_err", 32'(err16), 32'd1);
    chk("t4_multi_out", 32'(out16), 32'd0);
    step(1'b1, 8'h20);
    send_str("+");
    chk("t4_lead_err", 32'(err16), 32'd1);
    step(1'b1, 8'h20);
    send_str("1++2+3*4 9");
    chk("t4_sticky", 32'(err16), 32'd1);

    step(1'b1, 8'h20);
    send_str("9*9*9*9");
    chk("t5_res8", 32'(res8), 32'd161);
    chk("t5_res16", 32'(res16), 32'd6561);
    chk("t5_out8", 32'(out8), 32'd1);

    step(1'b1, 8'h20);
    send_str("1+");
    step(1'b1, 8'h35);
    chk("t6_clr_res", 32'(res16), 32'd0);
    chk("t6_clr_out", 32'(out16), 32'd0);
    send_str("4");
    chk("t6_result", 32'(res16), 32'd4);

    // Random streams, biased toward well-formed input so long expressions occur.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      want_digit = (q.size() == 0) || is_op(q[$]);
      if (r < 4) begin
        step(1'b1, 8'($urandom_range(255)));
      end else begin
        if (r < 14) c = other_chars[$urandom_range(other_chars.len() - 1)];
        else if ((r < 94) == want_digit) c = 8'h30 + 8'($urandom_range(9));
        else c = ($urandom_range(1) != 0) ? 8'h2B : 8'h2A;
        step(1'b0, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
